// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the demux feed sequencer and the 1-to-8 demux it drives.
package demux_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_feed_seq_lsb_find8.sv
// Lowest-set-bit finder: index of the lowest 1 in vec_i, none_o when vec_i is all zero.
module lsb_find8
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   vec_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             none_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = SEL_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_feed_seq.sv
// Serialises one accepted word onto the demux pins, one enabled channel per HOLD-cycle slot,
// lowest channel first, then pulses done for one cycle before accepting the next word.
module demux_feed_seq
  import demux_pkg::*;
#(
  parameter int unsigned HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   data_in,
  input  logic [NCH-1:0]   mask_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [SEL_W-1:0] demux_s,
  output logic             demux_in,
  output logic             demux_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  state_t           state_q, state_d;
  logic [NCH-1:0]   data_q, data_d;
  logic [NCH-1:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [SEL_W-1:0] ch;
  logic             rem_none;
  logic [NCH-1:0]   ch_onehot;
  logic [NCH-1:0]   rem_clr;
  logic [SEL_W-1:0] unused_idx;
  logic             last_slot;

  lsb_find8 u_pick (
    .vec_i  (rem_q),
    .idx_o  (ch),
    .none_o (rem_none)
  );

  always_comb begin
    ch_onehot     = '0;
    ch_onehot[ch] = 1'b1;
    rem_clr       = rem_q & ~ch_onehot;
  end

  // Current slot is the last one when nothing remains after clearing its bit.
  lsb_find8 u_last (
    .vec_i  (rem_clr),
    .idx_o  (unused_idx),
    .none_o (last_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          data_d  = data_in;
          rem_d   = mask_in;
          cnt_d   = '0;
          state_d = (mask_in != '0) ? SEND : DONE;
        end
      end
      SEND: begin
        if (cnt_q == CNT_LAST) begin
          rem_d = rem_clr;
          cnt_d = '0;
          if (last_slot || rem_none) state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode registered state only; data_valid never reaches them.
  always_comb begin
    data_ready = (state_q == IDLE);
    busy       = (state_q == SEND) || (state_q == DONE);
    done       = (state_q == DONE);
    demux_en   = (state_q == SEND);
    demux_s    = (state_q == SEND) ? ch : '0;
    demux_in   = (state_q == SEND) ? data_q[ch] : 1'b0;
  end

endmodule

// File: tb/tb_demux_feed_seq.sv
// Self-checking bench: directed table, multi-cycle corner sequences and random words vs. a slot-list model.
module tb_demux_feed_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in, mask_in;
  logic       v1, v2;

  logic       r1, r2, en1, en2, in1, in2, b1, b2, d1, d2;
  logic [2:0] s1, s2;

  int nvec = 0;
  int nmis = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  demux_feed_seq #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mask_in(mask_in), .data_valid(v1),
    .data_ready(r1), .demux_s(s1), .demux_in(in1), .demux_en(en1), .busy(b1), .done(d1)
  );

  demux_feed_seq #(.HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .mask_in(mask_in), .data_valid(v2),
    .data_ready(r2), .demux_s(s2), .demux_in(in2), .demux_en(en2), .busy(b2), .done(d2)
  );

  // Observation byte: {ready, busy, done, en, s[2:0], in}
  function automatic logic [7:0] pack(logic rdy, logic bsy, logic dn, logic en, logic [2:0] s, logic di);
    return {rdy, bsy, dn, en, s, di};
  endfunction

  localparam logic [7:0] IDLE_OBS = 8'h80;

  function automatic logic [7:0] obs(int sel);
    if (sel == 1) return pack(r1, b1, d1, en1, s1, in1);
    return pack(r2, b2, d2, en2, s2, in2);
  endfunction

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: each enabled channel, ascending, occupies HOLD cycles; then a done cycle; then ready.
  function automatic void build(logic [7:0] d, logic [7:0] m, int hold);
    exp_q.delete();
    for (int ch = 0; ch < 8; ch++)
      if (m[ch])
        for (int h = 0; h < hold; h++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b1, 3'(ch), d[ch]));
    exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0));
    exp_q.push_back(IDLE_OBS);
  endfunction

  task automatic offer(int sel, logic [7:0] d, logic [7:0] m);
    logic [7:0] o;
    o = obs(sel);
    chk("ready_before_accept", int'(o[7]), 1);
    data_in = d;
    mask_in = m;
    if (sel == 1) v1 = 1'b1; else v2 = 1'b1;
  endtask

  task automatic run_trace(int sel, logic [7:0] d, logic [7:0] m, int hold, bit keep,
                           logic [7:0] nd, logic [7:0] nm, output int dcyc);
    logic [7:0] o;
    logic prev_done;
    build(d, m, hold);
    dcyc = -1;
    prev_done = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      o = obs(sel);
      chk($sformatf("trace d=%02h m=%02h c=%0d", d, m, c + 1), int'(o), int'(exp_q[c]));
      chk("ready_while_busy", int'(o[7] & o[6]), 0);
      chk("done_width", int'(o[5] & prev_done), 0);
      if (!o[4]) chk("idle_pins_zero", int'(o[3:0]), 0);
      if (o[5] && dcyc < 0) dcyc = c + 1;
      prev_done = o[5];
      if (c == 0) begin
        data_in = nd;
        mask_in = nm;
        if (!keep) begin v1 = 1'b0; v2 = 1'b0; end
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
    int         sel;
    int         exp_done;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int dc;
    logic [7:0] rd, rm;
    int rsel;

    tbl[0] = '{8'hA5, 8'hFF, 2, 17};
    tbl[1] = '{8'hFF, 8'h81, 1, 3};
    tbl[2] = '{8'hFF, 8'h00, 2, 1};
    tbl[3] = '{8'h0F, 8'h0F, 2, 9};
    tbl[4] = '{8'h3C, 8'h5A, 1, 5};
    tbl[5] = '{8'h00, 8'h80, 2, 3};

    rst_n = 1'b0; v1 = 1'b0; v2 = 1'b0; data_in = 8'h00; mask_in = 8'h00;
    #3;
    chk("reset_dut1", int'(obs(1)), int'(IDLE_OBS));
    chk("reset_dut2", int'(obs(2)), int'(IDLE_OBS));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      offer(tbl[i].sel, tbl[i].data, tbl[i].mask);
      run_trace(tbl[i].sel, tbl[i].data, tbl[i].mask, tbl[i].sel, 1'b0,
                8'($urandom), 8'($urandom), dc);
      chk($sformatf("done_cycle vec%0d", i), dc, tbl[i].exp_done);
      @(negedge clk);
    end

    // Valid held high: second word only taken once ready returns; first word unaffected by data change.
    offer(2, 8'h01, 8'h03);
    run_trace(2, 8'h01, 8'h03, 2, 1'b1, 8'h02, 8'h03, dc);
    chk("held_valid_word1_done", dc, 5);
    run_trace(2, 8'h02, 8'h03, 2, 1'b0, 8'($urandom), 8'($urandom), dc);
    chk("held_valid_word2_done", dc, 5);
    @(negedge clk);

    // Reset mid-slot while s=3 is on the pins.
    offer(2, 8'hA5, 8'hFF);
    build(8'hA5, 8'hFF, 2);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("pre_reset c=%0d", c + 1), int'(obs(2)), int'(exp_q[c]));
      if (c == 0) v2 = 1'b0;
    end
    chk("pre_reset_sel3", int'(s2), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dut2", int'(obs(2)), int'(IDLE_OBS));
    chk("async_reset_dut1", int'(obs(1)), int'(IDLE_OBS));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("held_in_reset", int'(obs(2)), int'(IDLE_OBS));
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_after_reset", int'(obs(2)), int'(IDLE_OBS));
    end
    offer(2, 8'h0F, 8'h0F);
    run_trace(2, 8'h0F, 8'h0F, 2, 1'b0, 8'h00, 8'h00, dc);
    chk("post_reset_done", dc, 9);

    // Random words on both DUTs with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      rd = 8'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rsel = $urandom_range(1, 2);
      offer(rsel, rd, rm);
      run_trace(rsel, rd, rm, rsel, 1'b0, 8'($urandom), 8'($urandom), dc);
      chk("rand_done_cycle", dc, $countones(rm) * rsel + 1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("rand_idle", int'(obs(rsel)), int'(IDLE_OBS));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
